// File: rtl/mem_rd_pkg.sv
// Shared types and constants for the RAM read streamer.
// Holds the FSM encoding, default widths and skid sizing.
package mem_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int DW_DEF     = 16;
  localparam int AW_DEF     = 3;
  localparam int LW_DEF     = 4;
  localparam int SKID_DEPTH = 2;
  localparam int CW         = $clog2(SKID_DEPTH + 1);
  localparam int PW         = $clog2(SKID_DEPTH);

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    if (p == PW'(SKID_DEPTH - 1))
      return '0;
    return p + PW'(1);
  endfunction

endpackage

// File: rtl/mem_rd_streamer_if.sv
// Valid/ready word stream carried from the streamer
// to downstream logic.
interface mem_rd_streamer_if #(
  parameter int DW = 16
) ();

  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/mem_rd_skid.sv
// Small synchronous FIFO that absorbs the RAM read latency
// when the stream consumer stalls.
module mem_rd_skid
  import mem_rd_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count
);

  logic [SKID_DEPTH-1:0][DW-1:0] mem;
  logic [PW-1:0]                 wp;
  logic [PW-1:0]                 rp;

  assign dout = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ptr_inc(wp);
      end
      if (pop)
        rp <= ptr_inc(rp);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/mem_rd_streamer.sv
// Walks a RAM address range and streams the words out.
// Define RD_CHECKSUM_EN to add a running checksum output.
module mem_rd_streamer
  import mem_rd_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  mem_rd_streamer_if.master m
`ifdef RD_CHECKSUM_EN
  ,
  output logic [DW-1:0] checksum
`endif
);

  state_t        state;
  state_t        state_nxt;
  logic [LW-1:0] len_q;
  logic [LW-1:0] issued;
  logic [LW-1:0] xfer;
  logic          inflight;
  logic [CW-1:0] count;
  logic [2:0]    occ;
  logic          pop;
  logic          accept;
  logic          last_pop;
  logic          issue;

  assign pop      = m.m_valid && m.m_ready;
  assign accept   = (state == IDLE) && start;
  assign last_pop = pop && (xfer + LW'(1) == len_q);
  assign busy     = (state != IDLE);
  assign m.m_valid = (count != '0);

  // Counting the word leaving this cycle keeps one word per cycle.
  assign occ = 3'(count) + 3'(inflight) - 3'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && len != '0)
          state_nxt = RUN;
      end
      RUN: begin
        issue = (occ < 3'd2) && (issued < len_q);
        if (issue && issued + LW'(1) == len_q)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_pop)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr  <= '0;
      len_q    <= '0;
      issued   <= '0;
      xfer     <= '0;
      inflight <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (accept && len == '0) ||
              (state == DRAIN && last_pop);
      inflight <= issue;
      if (accept) begin
        rd_addr <= base_addr;
        len_q   <= len;
        issued  <= '0;
        xfer    <= '0;
      end else begin
        if (issue) begin
          rd_addr <= rd_addr + AW'(1);
          issued  <= issued + LW'(1);
        end
        if (pop)
          xfer <= xfer + LW'(1);
      end
    end
  end

  mem_rd_skid #(
    .DW(DW)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .din  (rd_data),
    .pop  (pop),
    .dout (m.m_data),
    .count(count)
  );

`ifdef RD_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      checksum <= '0;
    else if (accept)
      checksum <= '0;
    else if (pop)
      checksum <= checksum + m.m_data;
  end
`endif

endmodule

// File: tb/tb_mem_rd_streamer.sv
// Directed bench for mem_rd_streamer with a queue-based
// reference model and a per-cycle compare process.
module tb_mem_rd_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  base_addr = '0;
  logic [3:0]  len = '0;
  logic        busy;
  logic        done;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data = '0;
`ifdef RD_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  mem_rd_streamer_if #(.DW(16)) s ();

  int tests = 0;
  int fails = 0;

  logic [15:0] ram [8] = '{
    16'habcd, 16'h79ca, 16'h1358, 16'h976a,
    16'h84ad, 16'hd3f5, 16'hf4a2, 16'hc0d1
  };

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= ram[rd_addr];

  mem_rd_streamer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .m        (s)
`ifdef RD_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model state
  logic [15:0] exp_q[$];
  logic [2:0]  rd_log[$];
  bit          model_busy = 0;
  bit          done_exp = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_data = '0;
  logic [15:0] sum = '0;
  logic [15:0] last_word = '0;
  int          hs_count = 0;

  always @(negedge clk) begin : compare
    bit          nb;
    bit          nd;
    logic [2:0]  a;
    if (rst) begin
      exp_q.delete();
      rd_log.delete();
      model_busy = 0;
      done_exp   = 0;
      prev_stall = 0;
      sum        = '0;
      hs_count   = 0;
    end else begin
      chk("busy", 32'(busy), 32'(model_busy));
      chk("done", 32'(done), 32'(done_exp));
      chk("occupancy", 32'(dut.u_skid.count <= 2), 32'd1);
`ifdef RD_CHECKSUM_EN
      chk("checksum", 32'(checksum), 32'(sum));
`endif
      if (prev_stall) begin
        chk("stall_valid", 32'(s.m_valid), 32'd1);
        chk("stall_data", 32'(s.m_data), 32'(prev_data));
      end
      if (exp_q.size() == 0)
        chk("idle_valid", 32'(s.m_valid), 32'd0);
      if (model_busy &&
          (rd_log.size() == 0 || rd_log[$] != rd_addr))
        rd_log.push_back(rd_addr);
      nb = model_busy;
      nd = 0;
      if (s.m_valid && s.m_ready) begin
        chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("m_data", 32'(s.m_data), 32'(exp_q.pop_front()));
          sum       = sum + s.m_data;
          last_word = s.m_data;
          hs_count++;
          if (exp_q.size() == 0) begin
            nd = 1;
            nb = 0;
          end
        end
      end
      if (start && !model_busy) begin
        sum      = '0;
        hs_count = 0;
        rd_log.delete();
        if (len == 0) begin
          nd = 1;
        end else begin
          nb = 1;
          for (int i = 0; i < int'(len); i++) begin
            a = base_addr + 3'(i);
            exp_q.push_back(ram[a]);
          end
        end
      end
      prev_stall = s.m_valid && !s.m_ready;
      prev_data  = s.m_data;
      model_busy = nb;
      done_exp   = nd;
    end
  end

  task automatic do_start(input logic [2:0] b,
                          input logic [3:0] l);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = b;
    len       = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int mode, input bit inj,
                           output int cyc, output int fv);
    int p;
    cyc = -1;
    fv  = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      p = (k - 1) % 4;
      s.m_ready = (mode == 0) || (p == 0) || (p == 3);
      if (inj) begin
        if (k == 2) begin
          start     = 1'b1;
          base_addr = 3'd0;
          len       = 4'd5;
        end else begin
          start = 1'b0;
        end
      end
      @(negedge clk);
      if (fv < 0 && s.m_valid)
        fv = k;
      if (done) begin
        cyc = k;
        break;
      end
    end
    if (cyc < 0)
      chk("done_timeout", 32'(done), 32'd1);
    start     = 1'b0;
    s.m_ready = 1'b1;
  endtask

  initial begin : main
    int cyc;
    int fv;
    s.m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(s.m_valid), 32'd0);
    chk("rst_data", 32'(s.m_data), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0;

    // base 2, len 3, ready held high
    do_start(3'd2, 4'd3);
    wait_done(0, 0, cyc, fv);
    chk("t1_first_valid", 32'(fv), 32'd2);
    chk("t1_done_cycle", 32'(cyc), 32'd5);
    chk("t1_last_word", 32'(last_word), 32'h84ad);

    // wrap-around with an ignored mid-burst start
    do_start(3'd6, 4'd4);
    wait_done(0, 1, cyc, fv);
    chk("t2_done_cycle", 32'(cyc), 32'd6);
    chk("t2_last_word", 32'(last_word), 32'h79ca);
    chk("t2_log_size", 32'(rd_log.size() >= 4), 32'd1);
    if (rd_log.size() >= 4) begin
      chk("t2_addr0", 32'(rd_log[0]), 32'd6);
      chk("t2_addr1", 32'(rd_log[1]), 32'd7);
      chk("t2_addr2", 32'(rd_log[2]), 32'd0);
      chk("t2_addr3", 32'(rd_log[3]), 32'd1);
    end

    // full range under 1,0,0,1 backpressure
    do_start(3'd0, 4'd8);
    wait_done(1, 0, cyc, fv);
    chk("t3_last_word", 32'(last_word), 32'hc0d1);
    chk("t3_count", 32'(hs_count), 32'd8);

    // zero-length command
    do_start(3'd3, 4'd0);
    @(negedge clk);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_valid", 32'(s.m_valid), 32'd0);

    // reset in the middle of a burst
    do_start(3'd0, 4'd8);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (hs_count >= 2) break;
    end
    chk("t5_two_xfers", 32'(hs_count >= 2), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_valid", 32'(s.m_valid), 32'd0);
    chk("t5_data", 32'(s.m_data), 32'd0);
    chk("t5_addr", 32'(rd_addr), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    do_start(3'd4, 4'd1);
    wait_done(0, 0, cyc, fv);
    chk("t5_after_rst", 32'(last_word), 32'h84ad);

`ifdef RD_CHECKSUM_EN
    do_start(3'd0, 4'd2);
    wait_done(0, 0, cyc, fv);
    @(negedge clk);
    chk("t6_checksum", 32'(checksum), 32'h2597);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_rd_streamer.md
Name: mem_rd_streamer

Overview:
Read-side sequencer for the team's 8x16 synchronous-read RAM blocks. On a start command it walks a contiguous address range and drives the RAM read address. It then returns the words as a valid/ready stream to downstream logic. Backpressure is absorbed by a 2-entry skid buffer, so the RAM's fixed 1-cycle read latency never drops or duplicates a word.

Parameters:
DW, 16, data width (matches RAM word width)
AW, 3, RAM address width; addresses wrap modulo 2^AW
LW, 4, length field width; max burst length 2^LW-1

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle command strobe; sampled only in IDLE
base_addr  in  AW  first address of burst, captured on accepted start
len  in  LW  number of words to stream, captured on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last word is accepted downstream
rd_addr  out  AW  registered RAM read address
rd_data  in  DW  RAM registered output; valid the cycle after the address edge
m_data  out  DW  stream data
m_valid  out  1  stream valid
m_ready  in  1  stream ready; transfer when m_valid and m_ready

Behaviour:
- Reset (async, any time, including mid-burst) values: state=IDLE, busy=0, done=0, m_valid=0, m_data=0, rd_addr=0, skid empty, counters 0. Any in-flight read is discarded.
- FSM states:
  - IDLE: start=1 with len!=0 -> RUN. Captures base_addr and len; rd_addr<=base_addr; busy<=1.
  - IDLE: start=1 with len==0 -> done pulses next cycle; busy stays 0; no read issued.
  - RUN: issue reads. Exit to DRAIN when issued count == len.
  - DRAIN: wait until all words are transferred, then pulse done, drop busy, return to IDLE.
- Issue rule: a read issues on a cycle where (words in skid + reads in flight) < 2 and issued < len.
  - On issue, rd_addr advances +1 mod 2^AW for the next issue, so 7 -> 0.
  - In-flight flag is set for exactly one cycle after issue. rd_data is written into the skid on that cycle.
- Skid: 2-entry FIFO. m_data/m_valid reflect the head entry.
  - Simultaneous push and pop is legal and keeps occupancy unchanged.
  - m_data holds stable while m_valid=1 and m_ready=0.
  - Never overflows, by the issue rule.
- Throughput: with m_ready held high, one word per cycle after start. First m_valid appears 2 cycles after the start edge: cycle 1 presents the address, cycle 2 pushes into the skid.
- start while busy is ignored; no queueing.
- done asserts the cycle after the final handshake and is mutually exclusive with busy. start on the same cycle as done is accepted.

Optional Feature:
RD_CHECKSUM_EN
- Defined: adds output port checksum [DW-1:0].
  - Cleared on accepted start.
  - Adds each transferred m_data modulo 2^DW.
  - Holds its value after done until the next start. Reset value 0.
- Undefined: port and adder are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mem_rd_pkg: FSM state enum (IDLE, RUN, DRAIN), default DW/AW/LW constants, and the skid depth constant (2).
- One natural sub-module: mem_rd_skid, a 2-entry synchronous FIFO with push/pop/count, same clk/rst.

Test Plan:
Bench RAM model preloaded with addresses 0..7 = abcd,79ca,1358,976a,84ad,d3f5,f4a2,c0d1; 1-cycle read latency.
- base=2, len=3, m_ready=1 -> m_data 1358,976a,84ad on 3 consecutive cycles; done 1 cycle after the last; busy high throughout.
- base=6, len=4 -> wrap-around order f4a2,c0d1,abcd,79ca; rd_addr sequence 6,7,0,1.
- base=0, len=8, m_ready toggling 1,0,0,1 (repeat) -> all 8 words in order, none lost or duplicated; m_data stable while stalled; occupancy never exceeds 2.
- start with len=0 -> done pulse, m_valid stays 0, busy stays 0; a second start issued mid-burst is ignored.
- rst asserted mid-burst after 2 transfers -> outputs at reset values in the same cycle; a new start base=4, len=1 yields 84ad.
- RD_CHECKSUM_EN defined, base=0, len=2 -> checksum = 0x2597 (abcd+79ca mod 2^16) after done.
